// File: rtl/mux_pkg.sv
// mux_pkg: shared definitions for the 8x1 mux scan controller, the mux and
// their testbench.
//   SEL_W / N_CH  : select width and channel count (N_CH = 2**SEL_W)
//   CNT_W         : width of the settle counter
//   scan_state_e  : scan controller FSM states
package mux_pkg;

  localparam int unsigned SEL_W = 3;
  localparam int unsigned N_CH  = 2 ** SEL_W;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_HOLD   = 2'd3
  } scan_state_e;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [N_CH-1:0]  word_t;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// mux_scan_ctrl_if: bundle between the scan controller, the mux and the
// downstream word consumer.
//   start       scan request (to controller)
//   mux_o       mux output (to controller)
//   sel         mux select (from controller)
//   busy        scan in progress (from controller)
//   word        assembled samples (from controller)
//   word_valid  word complete (from controller)
//   word_ready  downstream accepts word (to controller)
// Modports: slave = controller side, master = environment side.
interface mux_scan_ctrl_if;
  import mux_pkg::*;

  logic  start;
  logic  mux_o;
  sel_t  sel;
  logic  busy;
  word_t word;
  logic  word_valid;
  logic  word_ready;

  modport slave (
    input  start, mux_o, word_ready,
    output sel, busy, word, word_valid
  );

  modport master (
    output start, mux_o, word_ready,
    input  sel, busy, word, word_valid
  );
endinterface

// File: rtl/mux_scan_ctrl_settle_counter.sv
// settle_counter: settle-interval counter for the scan controller.
//   clk, rst  clock and synchronous active-high reset
//   clr       clear count to 0 (priority over en)
//   en        increment count
//   tc        terminal count: en is high and count == TERM-1
module settle_counter
  import mux_pkg::*;
#(
  parameter int unsigned TERM = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  cnt_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = en && (cnt_q == cnt_t'(TERM - 1));

endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps the 8x1 mux select through channels 0..7, waits
// SETTLE cycles on each, samples mux_o for one cycle, and offers the
// assembled word downstream with a valid/ready handshake.
//   clk, rst  clock and synchronous active-high reset
//   bus       mux_scan_ctrl_if.slave (start, mux_o, sel, busy, word,
//             word_valid, word_ready)
// Parameter SETTLE (1..15): cycles sel is held before sampling.
// Macro SCAN_AUTO_RESTART_EN: when defined, the handshake edge starts the
// next scan directly instead of returning to idle.
module mux_scan_ctrl
  import mux_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input logic            clk,
  input logic            rst,
  mux_scan_ctrl_if.slave bus
);

  scan_state_e state_q, state_d;
  sel_t        sel_q, sel_d;
  word_t       word_q, word_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;

  logic cnt_en, cnt_clr, cnt_tc;

  // Counter runs only in SETTLE and is held at zero elsewhere, so every
  // entry into SETTLE starts a fresh interval.
  assign cnt_en  = (state_q == ST_SETTLE);
  assign cnt_clr = !cnt_en;

  settle_counter #(.TERM(SETTLE)) u_settle_counter (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    word_d  = word_q;
    valid_d = valid_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_SETTLE;
          sel_d   = '0;
          word_d  = '0;
        end
      end
      ST_SETTLE: begin
        if (cnt_tc) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        word_d[sel_q] = bus.mux_o;
        if (sel_q == sel_t'(N_CH - 1)) begin
          state_d = ST_HOLD;
          valid_d = 1'b1;
        end else begin
          sel_d   = sel_q + sel_t'(1);
          state_d = ST_SETTLE;
        end
      end
      ST_HOLD: begin
        if (valid_q && bus.word_ready) begin
          valid_d = 1'b0;
`ifdef SCAN_AUTO_RESTART_EN
          state_d = ST_SETTLE;
          sel_d   = '0;
          word_d  = '0;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // busy is registered from the next state so it lines up with state_q.
    busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.word       = word_q;
  assign bus.word_valid = valid_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: self-checking bench for mux_scan_ctrl. Two controllers
// (SETTLE=1 and SETTLE=3) each drive a behavioural 8x1 mux over a data
// vector. Expected words come from the per-edge history of the data vector:
// channel i is captured at edge start + (i+1)*(SETTLE+1).
module tb_mux_scan_ctrl;
  import mux_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_scan_ctrl_if bus1 ();
  mux_scan_ctrl_if bus3 ();

  word_t d1, d3;
  assign bus1.mux_o = d1[bus1.sel];
  assign bus3.mux_o = d3[bus3.sel];

  mux_scan_ctrl #(.SETTLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  mux_scan_ctrl #(.SETTLE(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

  int total = 0;
  int bad   = 0;

  // Edge counter and the mux data vectors as seen at each rising edge.
  int    ecnt = 0;
  word_t d1_at [int];
  word_t d3_at [int];
  always @(posedge clk) begin
    ecnt = ecnt + 1;
    d1_at[ecnt] = d1;
    d3_at[ecnt] = d3;
  end

  typedef struct {
    word_t d;
    word_t exp;
    int    mid_k;
    int    hold_n;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  function automatic logic [31:0] f_sel(input int w);
    return (w == 1) ? 32'(bus1.sel) : 32'(bus3.sel);
  endfunction
  function automatic logic [31:0] f_word(input int w);
    return (w == 1) ? 32'(bus1.word) : 32'(bus3.word);
  endfunction
  function automatic logic [31:0] f_valid(input int w);
    return (w == 1) ? 32'(bus1.word_valid) : 32'(bus3.word_valid);
  endfunction
  function automatic logic [31:0] f_busy(input int w);
    return (w == 1) ? 32'(bus1.busy) : 32'(bus3.busy);
  endfunction

  task automatic drive(input int w, input logic st, input logic rdy, input word_t dv);
    if (w == 1) begin
      bus1.start = st; bus1.word_ready = rdy; d1 = dv;
    end else begin
      bus3.start = st; bus3.word_ready = rdy; d3 = dv;
    end
  endtask

  task automatic check_reset_vals(input int w, input string tag);
    check({tag, "_sel"},   f_sel(w),   0);
    check({tag, "_word"},  f_word(w),  0);
    check({tag, "_valid"}, f_valid(w), 0);
    check({tag, "_busy"},  f_busy(w),  0);
  endtask

  // dmode: 0 constant dconst, 1 random every cycle,
  //        2 dconst only on sample edges and ~dconst on the others.
  task automatic run_scan(input int w, input int S, input int dmode, input word_t dconst,
                          input bit chk_fixed, input int mid_k, input int hold_n,
                          input bit rst_in_hold);
    int    L, s, e;
    word_t dv, exp, hv;
    L  = int'(N_CH) * (S + 1);
    dv = (dmode == 1) ? word_t'($urandom) : dconst;
    drive(w, 1'b1, 1'b0, dv);
    tick();
    s = ecnt;
    check("start_sel", f_sel(w), 0);
    check("start_busy", f_busy(w), 1);
    check("start_word_cleared", f_word(w), 0);
    for (int k = 1; k <= L; k++) begin
      case (dmode)
        0:       dv = dconst;
        1:       dv = word_t'($urandom);
        default: dv = ((k % (S + 1)) == 0) ? dconst : ~dconst;
      endcase
      drive(w, (k == mid_k), 1'($urandom), dv);
      tick();
      if (k < L) begin
        check("scan_sel", f_sel(w), k / (S + 1));
        check("scan_valid", f_valid(w), 0);
        check("scan_busy", f_busy(w), 1);
      end
    end
    exp = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      e  = s + int'(i + 1) * (S + 1);
      hv = (w == 1) ? d1_at[e] : d3_at[e];
      exp[i] = hv[i];
    end
    check("valid_rise", f_valid(w), 1);
    check("done_busy", f_busy(w), 0);
    check("done_sel", f_sel(w), N_CH - 1);
    check("word_model", f_word(w), 32'(exp));
    if (chk_fixed) check("word_fixed", f_word(w), 32'(dconst));
    for (int j = 0; j < hold_n; j++) begin
      drive(w, (j == hold_n / 2), 1'b0, word_t'($urandom));
      tick();
      check("hold_word", f_word(w), 32'(exp));
      check("hold_sel", f_sel(w), N_CH - 1);
      check("hold_valid", f_valid(w), 1);
      check("hold_busy", f_busy(w), 0);
    end
    if (rst_in_hold) begin
      rst = 1'b1;
      drive(w, 1'b1, 1'b1, '0);
      tick();
      rst = 1'b0;
      drive(w, 1'b0, 1'b0, '0);
      check_reset_vals(w, "rst_hold");
      tick();
      check("rst_hold_idle_busy", f_busy(w), 0);
      return;
    end
    drive(w, 1'b0, 1'b1, word_t'($urandom));
    tick();
    check("hs_valid_drop", f_valid(w), 0);
`ifdef SCAN_AUTO_RESTART_EN
    check("hs_restart_busy", f_busy(w), 1);
    check("hs_restart_sel", f_sel(w), 0);
    check("hs_restart_word", f_word(w), 0);
    drive(w, 1'b0, 1'b0, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
`else
    check("hs_idle_busy", f_busy(w), 0);
    check("hs_sel_kept", f_sel(w), N_CH - 1);
    check("hs_word_kept", f_word(w), 32'(exp));
    drive(w, 1'b0, 1'b0, '0);
    tick();
    check("idle_no_requeue_busy", f_busy(w), 0);
    check("idle_word_kept", f_word(w), 32'(exp));
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [7];
    int   guard;

    vecs[0] = '{d: 8'hB2, exp: 8'hB2, mid_k: -1, hold_n: 10};
    vecs[1] = '{d: 8'h00, exp: 8'h00, mid_k: 7,  hold_n: 2};
    vecs[2] = '{d: 8'hFF, exp: 8'hFF, mid_k: -1, hold_n: 0};
    vecs[3] = '{d: 8'h01, exp: 8'h01, mid_k: 7,  hold_n: 3};
    vecs[4] = '{d: 8'h80, exp: 8'h80, mid_k: 1,  hold_n: 1};
    vecs[5] = '{d: 8'h5A, exp: 8'h5A, mid_k: -1, hold_n: 4};
    vecs[6] = '{d: 8'hA5, exp: 8'hA5, mid_k: 15, hold_n: 2};

    rst = 1'b1;
    drive(1, 1'b0, 1'b0, '0);
    drive(3, 1'b0, 1'b0, '0);
    tick();
    tick();
    check_reset_vals(1, "reset1");
    check_reset_vals(3, "reset3");
    rst = 1'b0;

    // word_ready while idle has no effect.
    drive(1, 1'b0, 1'b1, 8'h3C);
    tick();
    check("idle_ready_valid", f_valid(1), 0);
    check("idle_ready_busy", f_busy(1), 0);
    drive(1, 1'b0, 1'b0, 8'h3C);

    // Constant-data scans; mid_k injects a start pulse during the scan.
    for (int v = 0; v < 7; v++) begin
      run_scan(1, 1, 0, vecs[v].d, 1'b0, vecs[v].mid_k, vecs[v].hold_n, 1'b0);
      check("table_word", f_word(1), 32'(vecs[v].exp));
    end

    // Reset at sel==5 aborts the scan; rst wins over start and word_ready.
    drive(1, 1'b1, 1'b0, 8'hC3);
    tick();
    drive(1, 1'b0, 1'b0, 8'hC3);
    guard = 0;
    while (bus1.sel != sel_t'(5) && guard < 100) begin
      tick();
      guard++;
    end
    check("reach_sel5", 32'(guard < 100), 1);
    rst = 1'b1;
    drive(1, 1'b1, 1'b1, 8'hC3);
    tick();
    rst = 1'b0;
    drive(1, 1'b0, 1'b0, 8'hC3);
    check_reset_vals(1, "rst_mid");
    tick();
    check("rst_mid_idle_busy", f_busy(1), 0);
    run_scan(1, 1, 0, 8'h6E, 1'b1, -1, 1, 1'b0);

    // Reset while holding a finished word.
    run_scan(1, 1, 1, '0, 1'b0, -1, 2, 1'b1);

    // SETTLE=3: only the sample-edge value may land in word.
    run_scan(3, 3, 2, 8'hFF, 1'b1, -1, 2, 1'b0);
    run_scan(3, 3, 2, 8'h96, 1'b1, 13, 1, 1'b0);

    // Randomized scans against the history model.
    for (int r = 0; r < 12; r++) begin
      int w, S;
      w = ($urandom_range(0, 1) == 0) ? 1 : 3;
      S = (w == 1) ? 1 : 3;
      run_scan(w, S, 1, '0, 1'b0,
               ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, 8 * (S + 1) - 1)),
               int'($urandom_range(0, 5)), 1'b0);
    end

`ifdef SCAN_AUTO_RESTART_EN
    begin
      int s;
      drive(1, 1'b1, 1'b1, 8'h4D);
      tick();
      s = ecnt;
      drive(1, 1'b0, 1'b1, 8'h4D);
      for (int c = 1; c <= 3 * 17 + 2; c++) begin
        tick();
        check("auto_valid", f_valid(1), 32'(c >= 16 && ((c - 16) % 17) == 0));
        if (c >= 16 && ((c - 16) % 17) == 0) check("auto_word", f_word(1), 32'h4D);
      end
      check("auto_start_edge", 32'(ecnt - s), 53);
      drive(1, 1'b0, 1'b0, '0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
